// File: rtl/pulse_selector_pkg.sv
// Mode encoding and 7-segment digit patterns shared by the display stages.
package pulse_selector_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_MED  = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT0 = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT1 = 7'b1111001;
    localparam logic [6:0] SEG_DIGIT2 = 7'b0100100;
    localparam logic [6:0] SEG_DIGIT3 = 7'b0110000;

    function automatic logic [6:0] seg_of(input logic [1:0] m);
        logic [6:0] s;
        s = SEG_DIGIT0;
        case (m)
            MODE_OFF:  s = SEG_DIGIT0;
            MODE_SLOW: s = SEG_DIGIT1;
            MODE_MED:  s = SEG_DIGIT2;
            MODE_FAST: s = SEG_DIGIT3;
            default:   s = SEG_DIGIT0;
        endcase
        return s;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_selector_tick_gen.sv
// Millisecond prescaler: free-running 0..TICK_DIV-1 counter with a one-cycle tick on the last count.
module tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int             CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pulse_selector.sv
// Registers the debounced mode, emits a periodic one-cycle pulse with a stretched wag level,
// and drives the 7-segment digit for the current mode.
module pulse_selector
    import pulse_selector_pkg::*;
#(
    parameter int TICK_DIV   = 50_000,
    parameter int PERIOD1_MS = 1000,
    parameter int PERIOD2_MS = 500,
    parameter int PERIOD3_MS = 250,
    parameter int HOLD_MS    = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_a,
    input  logic       sel_b,
    output logic [1:0] mode,
    output logic       pulse,
    output logic       wag,
    output logic [6:0] seg
);

    localparam int MAX_MS = max2(max2(PERIOD1_MS, PERIOD2_MS), max2(PERIOD3_MS, HOLD_MS));
    localparam int MW     = $clog2(MAX_MS + 1);

    logic [1:0]    sel_now;
    logic          mode_chg;
    logic          run;
    logic          tick;
    logic [MW-1:0] period;
    logic [MW-1:0] ms_cnt;
    logic [MW-1:0] hold_cnt;
    logic          ms_last;

    assign sel_now  = {sel_b, sel_a};
    assign mode_chg = (sel_now != mode);
    assign run      = (mode != MODE_OFF);

    always_comb begin
        period = MW'(PERIOD1_MS);
        case (mode)
            MODE_SLOW: period = MW'(PERIOD1_MS);
            MODE_MED:  period = MW'(PERIOD2_MS);
            MODE_FAST: period = MW'(PERIOD3_MS);
            default:   period = MW'(PERIOD1_MS);
        endcase
    end

    assign ms_last = (ms_cnt == period - MW'(1));

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (mode_chg),
        .en   (run),
        .tick (tick)
    );

    // A pending mode change wins over a coinciding terminal tick, so no stale pulse escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= MODE_OFF;
            seg      <= SEG_DIGIT0;
            ms_cnt   <= '0;
            hold_cnt <= '0;
            pulse    <= 1'b0;
            wag      <= 1'b0;
        end else begin
            mode <= sel_now;
            seg  <= seg_of(sel_now);
            if (mode_chg || !run) begin
                ms_cnt   <= '0;
                hold_cnt <= '0;
                pulse    <= 1'b0;
                wag      <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (tick) begin
                    if (ms_last) begin
                        // Reload on every pulse so a still-high wag is retriggered without a gap.
                        ms_cnt   <= '0;
                        pulse    <= 1'b1;
                        wag      <= 1'b1;
                        hold_cnt <= MW'(HOLD_MS);
                    end else begin
                        ms_cnt <= ms_cnt + MW'(1);
                        if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - MW'(1);
                            if (hold_cnt == MW'(1)) begin
                                wag <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_selector.sv
// Directed bench for pulse_selector: two instances differing only in HOLD_MS (1 and 2).
module tb_pulse_selector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_a = 1'b0;
    logic       sel_b = 1'b0;
    logic [1:0] mode_h1, mode_h2;
    logic       pulse_h1, pulse_h2;
    logic       wag_h1, wag_h2;
    logic [6:0] seg_h1, seg_h2;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;

    always #5 clk = ~clk;

    pulse_selector #(
        .TICK_DIV(4), .PERIOD1_MS(8), .PERIOD2_MS(4), .PERIOD3_MS(2), .HOLD_MS(1)
    ) dut_h1 (
        .clk(clk), .rst(rst), .sel_a(sel_a), .sel_b(sel_b),
        .mode(mode_h1), .pulse(pulse_h1), .wag(wag_h1), .seg(seg_h1)
    );

    pulse_selector #(
        .TICK_DIV(4), .PERIOD1_MS(8), .PERIOD2_MS(4), .PERIOD3_MS(2), .HOLD_MS(2)
    ) dut_h2 (
        .clk(clk), .rst(rst), .sel_a(sel_a), .sel_b(sel_b),
        .mode(mode_h2), .pulse(pulse_h2), .wag(wag_h2), .seg(seg_h2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [1:0] s);
        {sel_b, sel_a} = s;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        set_sel(2'b00);
        step();
        step();
        tests++;
        if ({mode_h1, pulse_h1, wag_h1, seg_h1} !== {2'd0, 1'b0, 1'b0, D0}) begin
            fails++;
            $display("FAIL reset_values: got mode=%0d pulse=%b wag=%b seg=%b, want 0 0 0 %b",
                     mode_h1, pulse_h1, wag_h1, seg_h1, D0);
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (mode_h1 !== 2'd0 || seg_h1 !== D0 || pulse_h1 !== 1'b0 || wag_h1 !== 1'b0 ||
                pulse_h2 !== 1'b0 || wag_h2 !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle_off: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_mode1();
        int bad;
        set_sel(2'b01);
        step();
        tests++;
        if (mode_h1 !== 2'd1 || seg_h1 !== D1 || pulse_h1 !== 1'b0) begin
            fails++;
            $display("FAIL mode1_entry: got mode=%0d seg=%b pulse=%b, want 1 %b 0",
                     mode_h1, seg_h1, pulse_h1, D1);
        end
        for (int rep = 0; rep < 3; rep++) begin
            bad = 0;
            for (int k = 1; k < 32; k++) begin
                step();
                if (pulse_h1 !== 1'b0 || wag_h1 !== ((rep > 0 && k < 4) ? 1'b1 : 1'b0)) bad++;
            end
            step();
            tests++;
            if (bad != 0 || pulse_h1 !== 1'b1 || wag_h1 !== 1'b1) begin
                fails++;
                $display("FAIL mode1_pulse%0d: bad=%0d pulse=%b wag=%b, want 0 1 1",
                         rep, bad, pulse_h1, wag_h1);
            end
        end
    endtask

    task automatic test_fast();
        int bad;
        set_sel(2'b11);
        step();
        tests++;
        if (mode_h1 !== 2'd3 || seg_h1 !== D3 || pulse_h1 !== 1'b0 || wag_h1 !== 1'b0 ||
            wag_h2 !== 1'b0) begin
            fails++;
            $display("FAIL mode3_entry: got mode=%0d seg=%b pulse=%b wag1=%b wag2=%b, want 3 %b 0 0 0",
                     mode_h1, seg_h1, pulse_h1, wag_h1, wag_h2, D3);
        end
        for (int rep = 0; rep < 3; rep++) begin
            bad = 0;
            for (int k = 1; k < 8; k++) begin
                step();
                if (pulse_h1 !== 1'b0 || pulse_h2 !== 1'b0) bad++;
                if (wag_h1 !== ((rep > 0 && k < 4) ? 1'b1 : 1'b0)) bad++;
                if (wag_h2 !== ((rep > 0) ? 1'b1 : 1'b0)) bad++;
            end
            step();
            tests++;
            if (bad != 0 || pulse_h1 !== 1'b1 || pulse_h2 !== 1'b1 || wag_h1 !== 1'b1 ||
                wag_h2 !== 1'b1) begin
                fails++;
                $display("FAIL mode3_pulse%0d: bad=%0d p1=%b p2=%b w1=%b w2=%b, want 0 1 1 1 1",
                         rep, bad, pulse_h1, pulse_h2, wag_h1, wag_h2);
            end
        end
    endtask

    task automatic test_switch_at_terminal();
        int bad;
        bad = 0;
        for (int k = 1; k < 8; k++) begin
            step();
            if (pulse_h1 !== 1'b0 || wag_h2 !== 1'b1) bad++;
        end
        // now in the cycle of the terminal tick
        set_sel(2'b10);
        step();
        tests++;
        if (bad != 0 || mode_h1 !== 2'd2 || seg_h1 !== D2 || pulse_h1 !== 1'b0 ||
            pulse_h2 !== 1'b0 || wag_h2 !== 1'b0) begin
            fails++;
            $display("FAIL switch_terminal: bad=%0d mode=%0d seg=%b p1=%b p2=%b w2=%b, want 0 2 %b 0 0 0",
                     bad, mode_h1, seg_h1, pulse_h1, pulse_h2, wag_h2, D2);
        end
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (pulse_h1 !== 1'b0 || pulse_h2 !== 1'b0 || wag_h2 !== 1'b0) bad++;
        end
        step();
        tests++;
        if (bad != 0 || pulse_h1 !== 1'b1 || pulse_h2 !== 1'b1) begin
            fails++;
            $display("FAIL mode2_first_pulse: bad=%0d p1=%b p2=%b, want 0 1 1", bad, pulse_h1, pulse_h2);
        end
    endtask

    task automatic test_off_while_wag();
        int bad;
        set_sel(2'b00);
        step();
        tests++;
        if (mode_h1 !== 2'd0 || seg_h1 !== D0 || pulse_h1 !== 1'b0 || wag_h1 !== 1'b0 ||
            wag_h2 !== 1'b0) begin
            fails++;
            $display("FAIL off_entry: mode=%0d seg=%b pulse=%b w1=%b w2=%b, want 0 %b 0 0 0",
                     mode_h1, seg_h1, pulse_h1, wag_h1, wag_h2, D0);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (pulse_h1 !== 1'b0 || wag_h1 !== 1'b0 || pulse_h2 !== 1'b0 || wag_h2 !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL off_quiet: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        set_sel(2'b10);
        step();
        for (int k = 1; k <= 17; k++) step();
        tests++;
        if (mode_h1 !== 2'd2 || wag_h1 !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_state: mode=%0d wag=%b, want 2 1", mode_h1, wag_h1);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (mode_h1 !== 2'd0 || seg_h1 !== D0 || pulse_h1 !== 1'b0 || wag_h1 !== 1'b0 ||
            wag_h2 !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: mode=%0d seg=%b pulse=%b w1=%b w2=%b, want 0 %b 0 0 0",
                     mode_h1, seg_h1, pulse_h1, wag_h1, wag_h2, D0);
        end
        step();
        step();
        rst = 1'b0;
        step();
        tests++;
        if (mode_h1 !== 2'd2 || seg_h1 !== D2 || pulse_h1 !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_mode: mode=%0d seg=%b pulse=%b, want 2 %b 0",
                     mode_h1, seg_h1, pulse_h1, D2);
        end
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (pulse_h1 !== 1'b0) bad++;
        end
        step();
        tests++;
        if (bad != 0 || pulse_h1 !== 1'b1 || wag_h1 !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_pulse: bad=%0d pulse=%b wag=%b, want 0 1 1", bad, pulse_h1, wag_h1);
        end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_fast();
        test_switch_at_terminal();
        test_off_while_wag();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pulse_selector.md
# pulse_selector

Downstream consumer of the button debouncer's 2-bit mode counter. Registers the mode, generates a periodic one-cycle `pulse` and a stretched `wag` level at one of three selectable rates (mode 0 = off), and drives the 7-segment digit showing the current mode. Feeds the actuator/LED stage of the toy dog.

## Interface
- `TICK_DIV`, 50_000: clk cycles per 1 ms tick (50 MHz clock); ≥2.
- `PERIOD1_MS`, 1000: pulse period in mode 1, ms; ≥1.
- `PERIOD2_MS`, 500: pulse period in mode 2, ms; ≥1.
- `PERIOD3_MS`, 250: pulse period in mode 3, ms; ≥1.
- `HOLD_MS`, 100: `wag` high time after each pulse, ms; ≥1.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `sel_a`  in  1  mode bit 0 (debouncer output A), synchronous to `clk`.
- `sel_b`  in  1  mode bit 1 (debouncer output B), synchronous to `clk`.
- `mode`  out  2  registered mode, `{sel_b, sel_a}` delayed one cycle.
- `pulse`  out  1  one-cycle strobe at the selected period.
- `wag`  out  1  level, high for HOLD_MS ms after each `pulse`.
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a} showing digit `mode`.

## Operation
- Reset values: `mode`=0, `pulse`=0, `wag`=0, `seg`=7'b1000000 (digit 0); prescaler, ms counter, hold counter all 0.
- `mode` register loads `{sel_b, sel_a}` every cycle. A "mode change" is a cycle where the loaded value differs from the current `mode`.
- Prescaler counts 0..TICK_DIV-1, wraps; `tick` internal strobe when count == TICK_DIV-1.
- ms counter counts ticks 0..P-1, P = period of current mode. On the tick where it equals P-1 it wraps to 0 and `pulse` is asserted on the next cycle (registered).
- Mode change (including into mode 0): prescaler, ms counter, hold counter cleared; `pulse` and `wag` forced 0 in the cycle the new mode appears on `mode`. Mode change beats a coinciding terminal tick: no pulse emitted.
- Mode 0: prescaler and ms counter held at 0; `pulse` and `wag` stay 0.
- `wag`: rises with `pulse`; hold counter loaded with HOLD_MS, decremented on each tick; `wag` falls when it reaches 0. A pulse while `wag` is high reloads the counter (retrigger, no gap).
- `seg` decodes `mode` combinationally-free (registered with `mode`): 0→1000000, 1→1111001, 2→0100100, 3→0110000.
- Counter widths sized by $clog2 of the largest parameter; no overflow reachable.

## Timing
- `sel_*` → `mode`/`seg`: 1 cycle latency.
- With `mode` first showing mode n ≠ 0 at cycle t, first `pulse` at cycle t + Pn·TICK_DIV; subsequent pulses every Pn·TICK_DIV cycles exactly.
- `pulse` width exactly 1 cycle. `wag` high for HOLD_MS·TICK_DIV cycles ± 1 tick alignment: starts with `pulse`, ends on the HOLD_MS-th tick after it.
- If HOLD_MS ≥ Pn, `wag` stays continuously high in mode n after the first pulse.
- `rst` asserted mid-operation: all outputs return to reset values immediately (asynchronously); operation restarts from cycle after deassertion as from a mode change into the sampled mode.

## Structure
- Shared package: mode encoding constants (MODE_OFF, MODE_SLOW, MODE_MED, MODE_FAST) and the four active-low segment patterns, reused by other display stages.
- One sub-module: `tick_gen` (parameter TICK_DIV; ports clk, rst, clr, en, tick) for the ms prescaler. Rest (mode register, ms counter, hold counter, seg decode) in the top.

## Test plan
Bench parameters: TICK_DIV=4, PERIOD1_MS=8, PERIOD2_MS=4, PERIOD3_MS=2, HOLD_MS=1.
- Reset, sel=00 for 100 cycles → `mode`=0, `seg`=1000000, `pulse`/`wag` never high.
- sel=01 at cycle t → `mode`=1, `seg`=1111001 at t+1; pulses at t+1+32, t+1+64, …; `wag` high 4 cycles from each pulse.
- sel=11 → pulse every 8 cycles, `seg`=0110000; HOLD_MS=2 rerun → `wag` continuously high after first pulse.
- Switch 11→10 on the cycle before a terminal tick → no pulse that cycle, `wag` drops, next pulse 16 cycles after `mode`=2.
- Switch to 00 while `wag` high → `wag`=0 in same cycle `mode`=0; no further pulses.
- Assert `rst` mid-period in mode 2 → outputs cleared without waiting for clk edge; after release with sel=10, first pulse 16 cycles after `mode`=2.
